// File: rtl/sseg_scan_driver_if.sv
// Pattern/display bundle between the pattern generators and sseg_scan_driver.
// Optional SSEG_BLINK_EN adds the per-digit blink request.
interface sseg_scan_driver_if;
  logic [6:0] in0_i;
  logic [6:0] in1_i;
  logic [6:0] in2_i;
  logic [6:0] in3_i;
  logic [3:0] dp_i;
  logic       enable_i;
  logic [3:0] brightness_i;
`ifdef SSEG_BLINK_EN
  logic [3:0] blink_i;
`endif
  logic [3:0] an_o;
  logic [6:0] sseg_o;
  logic       dp_o;
  logic       frame_o;

`ifdef SSEG_BLINK_EN
  modport master (output in0_i, in1_i, in2_i, in3_i, dp_i, enable_i, brightness_i, blink_i,
                  input  an_o, sseg_o, dp_o, frame_o);
  modport slave  (input  in0_i, in1_i, in2_i, in3_i, dp_i, enable_i, brightness_i, blink_i,
                  output an_o, sseg_o, dp_o, frame_o);
`else
  modport master (output in0_i, in1_i, in2_i, in3_i, dp_i, enable_i, brightness_i,
                  input  an_o, sseg_o, dp_o, frame_o);
  modport slave  (input  in0_i, in1_i, in2_i, in3_i, dp_i, enable_i, brightness_i,
                  output an_o, sseg_o, dp_o, frame_o);
`endif
endinterface

// File: rtl/sseg_scan_driver.sv
// Common-anode 4-digit scan driver: frame snapshot, dead time, 16-level PWM.
// Optional SSEG_BLINK_EN: per-digit blink gated by bit 7 of a frame counter.
module sseg_scan_driver #(
  parameter int SLOT_CYCLES = 100000,
  parameter int DEAD_CYCLES = 1000,
  parameter int CW          = $clog2(SLOT_CYCLES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sseg_scan_driver_if.slave  bus
);

  typedef enum logic {ST_DEAD, ST_ON} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      digit_q, digit_d;
  logic [3:0][6:0] snap_q, snap_d;
  logic [3:0]      snap_dp_q, snap_dp_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      sseg_q, sseg_d;
  logic            dp_q, dp_d;
  logic            frame_q, frame_d;
  logic            wrap, take_snap, lit;
`ifdef SSEG_BLINK_EN
  logic [3:0]      blink_snap_q, blink_snap_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
`endif

  always_comb begin
    wrap      = (cnt_q == CW'(SLOT_CYCLES - 1));
    take_snap = (digit_q == 2'd0) && (cnt_q == '0);
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    digit_d   = wrap ? digit_q + 2'd1 : digit_q;

    state_d = state_q;
    if (wrap)
      state_d = ST_DEAD;
    else if (cnt_q == CW'(DEAD_CYCLES - 1))
      state_d = ST_ON;

    snap_d    = take_snap ? {bus.in3_i, bus.in2_i, bus.in1_i, bus.in0_i} : snap_q;
    snap_dp_d = take_snap ? bus.dp_i : snap_dp_q;
    frame_d   = take_snap;

    // PWM phase is the low nibble of the slot counter, compared live.
    lit = (state_q == ST_ON) && bus.enable_i && (cnt_q[3:0] <= bus.brightness_i);
`ifdef SSEG_BLINK_EN
    blink_snap_d = take_snap ? bus.blink_i : blink_snap_q;
    frame_cnt_d  = frame_q ? frame_cnt_q + 8'd1 : frame_cnt_q;
    if (blink_snap_q[digit_q] && frame_cnt_q[7])
      lit = 1'b0;
`endif

    an_d   = lit ? ~(4'b0001 << digit_q) : 4'b1111;
    sseg_d = lit ? snap_q[digit_q] : 7'b1111111;
    dp_d   = lit ? snap_dp_q[digit_q] : 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_DEAD;
      cnt_q     <= '0;
      digit_q   <= 2'd0;
      snap_q    <= {4{7'b1111111}};
      snap_dp_q <= 4'b1111;
      an_q      <= 4'b1111;
      sseg_q    <= 7'b1111111;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
`ifdef SSEG_BLINK_EN
      blink_snap_q <= 4'b0000;
      frame_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      an_q      <= an_d;
      sseg_q    <= sseg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
`ifdef SSEG_BLINK_EN
      blink_snap_q <= blink_snap_d;
      frame_cnt_q  <= frame_cnt_d;
`endif
    end
  end

  assign bus.an_o    = an_q;
  assign bus.sseg_o  = sseg_q;
  assign bus.dp_o    = dp_q;
  assign bus.frame_o = frame_q;

endmodule
